// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if - LCD bus bundle between an MCU (master) and the
// lcd_bus_receiver model (slave).
//   lcd_dataout    MCU -> LCD nibble (DB7..DB4)
//   lcd_control    MCU -> LCD {E, RW, RS}
//   lcd_datain     LCD -> MCU nibble returned on read strobes
//   byte_data      last assembled byte
//   byte_rs        RS of last assembled byte (0 = command, 1 = data)
//   byte_valid     one-cycle pulse, byte_data/byte_rs updated
//   rs_error       one-cycle pulse, RS mismatch between nibbles
//   busy           modelled LCD busy flag
//   busy_violation one-cycle pulse, write strobe completed while busy
interface lcd_bus_receiver_if;
    logic [3:0] lcd_dataout;
    logic [2:0] lcd_control;
    logic [3:0] lcd_datain;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       byte_valid;
    logic       rs_error;
    logic       busy;
    logic       busy_violation;

    modport master (
        output lcd_dataout, lcd_control,
        input  lcd_datain, byte_data, byte_rs, byte_valid, rs_error, busy, busy_violation
    );

    modport slave (
        input  lcd_dataout, lcd_control,
        output lcd_datain, byte_data, byte_rs, byte_valid, rs_error, busy, busy_violation
    );
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver - receiver model of a 4-bit HD44780-style LCD bus.
// Detects falling edges of E, assembles high/low nibble pairs into bytes,
// flags RS mismatches between nibbles, and answers read strobes.
//   clk    rising-edge clock shared with the MCU
//   clear  asynchronous active-high reset
//   bus    lcd_bus_receiver_if.slave (see interface for signal list)
// Parameter BUSY_CYCLES (1..65535): busy duration after each assembled byte.
// Optional feature: define LCD_BUSY_MODEL_EN to enable the busy-flag counter;
// without it busy/busy_violation are tied low.
module lcd_bus_receiver #(
    parameter int unsigned BUSY_CYCLES = 40
) (
    input logic              clk,
    input logic              clear,
    lcd_bus_receiver_if.slave bus
);

    localparam logic [0:0] StHi = 1'b0;
    localparam logic [0:0] StLo = 1'b1;

    if (BUSY_CYCLES < 1 || BUSY_CYCLES > 65535) begin : g_bad_busy_cycles
        $error("BUSY_CYCLES out of range 1..65535");
    end

    logic e_in, rw_in, rs_in;
    assign e_in  = bus.lcd_control[2];
    assign rw_in = bus.lcd_control[1];
    assign rs_in = bus.lcd_control[0];

    logic       e_q, e_d;
    logic [3:0] nib_q, nib_d;
    logic       rs_lat_q, rs_lat_d;
    logic       rw_lat_q, rw_lat_d;
    logic [0:0] state_q, state_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic       hi_rs_q, hi_rs_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_rs_q, byte_rs_d;
    logic       byte_valid_q, byte_valid_d;
    logic       rs_error_q, rs_error_d;
    logic       rd_phase_q, rd_phase_d;
    logic       busy;

    // Strobe end uses the bus values latched in the last E=1 cycle.
    logic strobe_end, wr_strobe, rd_strobe;
    assign strobe_end = e_q & ~e_in;
    assign wr_strobe  = strobe_end & ~rw_lat_q;
    assign rd_strobe  = strobe_end & rw_lat_q;

    always_comb begin
        e_d          = e_in;
        nib_d        = nib_q;
        rs_lat_d     = rs_lat_q;
        rw_lat_d     = rw_lat_q;
        state_d      = state_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        byte_data_d  = byte_data_q;
        byte_rs_d    = byte_rs_q;
        byte_valid_d = 1'b0;
        rs_error_d   = 1'b0;
        rd_phase_d   = rd_phase_q;

        if (e_in) begin
            nib_d    = bus.lcd_dataout;
            rs_lat_d = rs_in;
            rw_lat_d = rw_in;
        end

        if (rd_strobe) begin
            rd_phase_d = ~rd_phase_q;
        end

        if (wr_strobe) begin
            if (state_q == StHi) begin
                hi_nib_d = nib_q;
                hi_rs_d  = rs_lat_q;
                state_d  = StLo;
            end else if (rs_lat_q == hi_rs_q) begin
                byte_data_d  = {hi_nib_q, nib_q};
                byte_rs_d    = rs_lat_q;
                byte_valid_d = 1'b1;
                state_d      = StHi;
            end else begin
                // Resynchronise: the mismatching nibble becomes the new high nibble.
                rs_error_d = 1'b1;
                hi_nib_d   = nib_q;
                hi_rs_d    = rs_lat_q;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            e_q          <= 1'b0;
            nib_q        <= 4'h0;
            rs_lat_q     <= 1'b0;
            rw_lat_q     <= 1'b0;
            state_q      <= StHi;
            hi_nib_q     <= 4'h0;
            hi_rs_q      <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_rs_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            rs_error_q   <= 1'b0;
            rd_phase_q   <= 1'b0;
        end else begin
            e_q          <= e_d;
            nib_q        <= nib_d;
            rs_lat_q     <= rs_lat_d;
            rw_lat_q     <= rw_lat_d;
            state_q      <= state_d;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            byte_data_q  <= byte_data_d;
            byte_rs_q    <= byte_rs_d;
            byte_valid_q <= byte_valid_d;
            rs_error_q   <= rs_error_d;
            rd_phase_q   <= rd_phase_d;
        end
    end

`ifdef LCD_BUSY_MODEL_EN
    localparam logic [15:0] BusyLoad = 16'(BUSY_CYCLES);

    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic        busy_violation_q, busy_violation_d;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (byte_valid_q) begin
            busy_cnt_d = BusyLoad;
        end else if (busy_cnt_q != 16'd0) begin
            busy_cnt_d = busy_cnt_q - 16'd1;
        end
        // Violating writes are still captured by the FSM above.
        busy_violation_d = wr_strobe & busy;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            busy_cnt_q       <= 16'd0;
            busy_violation_q <= 1'b0;
        end else begin
            busy_cnt_q       <= busy_cnt_d;
            busy_violation_q <= busy_violation_d;
        end
    end

    assign busy               = (busy_cnt_q != 16'd0);
    assign bus.busy_violation = busy_violation_q;
`else
    assign busy               = 1'b0;
    assign bus.busy_violation = 1'b0;
`endif

    assign bus.busy       = busy;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_rs    = byte_rs_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.rs_error   = rs_error_q;
    // Status read: busy flag on the high-nibble phase, zero on the low phase.
    assign bus.lcd_datain = (e_in && rw_in && !rd_phase_q) ? {busy, 3'b000} : 4'h0;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver - directed self-checking bench for lcd_bus_receiver.
// Expected busy behaviour follows LCD_BUSY_MODEL_EN as seen by this file.
module tb_lcd_bus_receiver;

`ifdef LCD_BUSY_MODEL_EN
    localparam bit BusyEn = 1'b1;
`else
    localparam bit BusyEn = 1'b0;
`endif
    localparam logic [3:0] BusyNib = BusyEn ? 4'h8 : 4'h0;

    logic clk;
    logic clear;
    lcd_bus_receiver_if bus_if ();

    lcd_bus_receiver #(
        .BUSY_CYCLES(40)
    ) u_dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bytes  = 0;
    int n_rs_err = 0;
    int n_viol   = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Event log of the output pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus_if.byte_valid) begin
            n_bytes++;
            if (bus_if.byte_data == 8'h41 || bus_if.byte_data == 8'hA4 ||
                bus_if.byte_data == 8'hF4) begin
                n_bad++;
            end
        end
        if (bus_if.rs_error) n_rs_err++;
        if (bus_if.busy_violation) n_viol++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One write nibble: E high for one cycle; returns in the strobe-end cycle.
    task automatic wr(input logic [3:0] nib, input logic rs);
        step();
        bus_if.lcd_control = {1'b1, 1'b0, rs};
        bus_if.lcd_dataout = nib;
        step();
        bus_if.lcd_control = {1'b0, 1'b0, rs};
        bus_if.lcd_dataout = 4'h0;
    endtask

    // One read strobe; checks lcd_datain while E is high.
    task automatic rd(input string tag, input logic [3:0] exp);
        step();
        bus_if.lcd_control = 3'b110;
        bus_if.lcd_dataout = 4'h0;
        @(negedge clk);
        check_eq(tag, 16'(bus_if.lcd_datain), 16'(exp));
        step();
        bus_if.lcd_control = 3'b010;
    endtask

    task automatic idle(input int n);
        bus_if.lcd_control = 3'b000;
        repeat (n) step();
    endtask

    initial begin
        clear              = 1'b1;
        bus_if.lcd_control = 3'b000;
        bus_if.lcd_dataout = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_byte_data", 16'(bus_if.byte_data), 16'h00);
        check_eq("rst_byte_rs", 16'(bus_if.byte_rs), 16'h0);
        check_eq("rst_byte_valid", 16'(bus_if.byte_valid), 16'h0);
        check_eq("rst_rs_error", 16'(bus_if.rs_error), 16'h0);
        check_eq("rst_busy", 16'(bus_if.busy), 16'h0);
        check_eq("rst_busy_violation", 16'(bus_if.busy_violation), 16'h0);
        check_eq("rst_datain", 16'(bus_if.lcd_datain), 16'h0);
        clear = 1'b0;
        idle(2);

        // Command byte 0x38, back-to-back nibbles.
        wr(4'h3, 1'b0);
        wr(4'h8, 1'b0);
        check_eq("b38_not_early", 16'(bus_if.byte_valid), 16'h0);
        step();
        check_eq("b38_valid", 16'(bus_if.byte_valid), 16'h1);
        check_eq("b38_data", 16'(bus_if.byte_data), 16'h38);
        check_eq("b38_rs", 16'(bus_if.byte_rs), 16'h0);
        step();
        check_eq("b38_pulse_end", 16'(bus_if.byte_valid), 16'h0);
        check_eq("b38_hold", 16'(bus_if.byte_data), 16'h38);
        idle(50);

        // RS mismatch resynchronises on the second nibble.
        wr(4'h4, 1'b1);
        wr(4'h1, 1'b0);
        step();
        check_eq("rserr_pulse", 16'(bus_if.rs_error), 16'h1);
        check_eq("rserr_no_byte", 16'(bus_if.byte_valid), 16'h0);
        wr(4'h5, 1'b0);
        step();
        check_eq("b15_valid", 16'(bus_if.byte_valid), 16'h1);
        check_eq("b15_data", 16'(bus_if.byte_data), 16'h15);
        check_eq("b15_rs", 16'(bus_if.byte_rs), 16'h0);
        idle(50);

        // Clear mid-byte; an E fall coincident with clear release is ignored.
        wr(4'hA, 1'b1);
        step();
        clear              = 1'b1;
        bus_if.lcd_control = 3'b101;
        bus_if.lcd_dataout = 4'hF;
        step();
        clear              = 1'b0;
        bus_if.lcd_control = 3'b001;
        bus_if.lcd_dataout = 4'h0;
        check_eq("clr_data", 16'(bus_if.byte_data), 16'h00);
        wr(4'h4, 1'b1);
        wr(4'h2, 1'b1);
        step();
        check_eq("b42_valid", 16'(bus_if.byte_valid), 16'h1);
        check_eq("b42_data", 16'(bus_if.byte_data), 16'h42);
        check_eq("b42_rs", 16'(bus_if.byte_rs), 16'h1);
        idle(50);

        // Read strobe between nibbles does not disturb assembly.
        wr(4'h2, 1'b1);
        rd("rd_mid_byte", 4'h0);
        wr(4'h8, 1'b1);
        step();
        check_eq("b28_valid", 16'(bus_if.byte_valid), 16'h1);
        check_eq("b28_data", 16'(bus_if.byte_data), 16'h28);
        check_eq("b28_rs", 16'(bus_if.byte_rs), 16'h1);
        // Read phase is now 1: low-nibble read returns 0 even while busy.
        rd("rd_phase_low", 4'h0);
        idle(50);

        // Busy window after byte 0x01 (byte_valid cycle = S+1).
        wr(4'h0, 1'b0);
        wr(4'h1, 1'b0);
        step();
        check_eq("b01_valid", 16'(bus_if.byte_valid), 16'h1);
        check_eq("b01_data", 16'(bus_if.byte_data), 16'h01);
        check_eq("busy_not_yet", 16'(bus_if.busy), 16'h0);
        rd("rd_busy_hi", BusyNib);
        rd("rd_busy_lo", 4'h0);
        repeat (36) step();
        check_eq("busy_last_cycle", 16'(bus_if.busy), 16'(BusyEn));
        step();
        check_eq("busy_expired", 16'(bus_if.busy), 16'h0);
        rd("rd_after_busy", 4'h0);
        idle(50);

        // Writes started inside the busy window flag a violation but are captured.
        wr(4'h0, 1'b0);
        wr(4'h2, 1'b0);
        step();
        check_eq("b02_data", 16'(bus_if.byte_data), 16'h02);
        wr(4'h3, 1'b0);
        step();
        check_eq("viol_pulse", 16'(bus_if.busy_violation), 16'(BusyEn));
        wr(4'h4, 1'b0);
        step();
        check_eq("b34_data", 16'(bus_if.byte_data), 16'h34);
        check_eq("b34_valid", 16'(bus_if.byte_valid), 16'h1);
        idle(50);

        check_eq("byte_count", 16'(n_bytes), 16'd7);
        check_eq("rs_error_count", 16'(n_rs_err), 16'd1);
        check_eq("violation_count", 16'(n_viol), BusyEn ? 16'd2 : 16'd0);
        check_eq("bad_bytes", 16'(n_bad), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 Parameter BUSY_CYCLES, default 40: busy-flag duration in clk cycles after each assembled byte; legal range 1..65535.
REQ-002 clk  input  1  single rising-edge clock, shared with the MCU driving the LCD bus.
REQ-003 clear  input  1  asynchronous, active-high reset.
REQ-004 lcd_dataout  input  4  nibble driven by the MCU (LCD DB7..DB4).
REQ-005 lcd_control  input  3  bit[2]=E, bit[1]=RW, bit[0]=RS.
REQ-006 lcd_datain  output  4  nibble returned to the MCU on read strobes.
REQ-007 byte_data  output  8  last assembled byte.
REQ-008 byte_rs  output  1  RS of last assembled byte (0=command, 1=data).
REQ-009 byte_valid  output  1  one-cycle pulse, byte_data/byte_rs new.
REQ-010 rs_error  output  1  one-cycle pulse, RS mismatch between nibbles.
REQ-011 busy  output  1  modelled LCD busy flag.
REQ-012 busy_violation  output  1  one-cycle pulse, write strobe completed while busy.

Function
REQ-013 E sampled into e_q each clk; strobe end = e_q=1 and E=0 (falling edge), detected in that cycle.
REQ-014 While E=1, lcd_dataout, RS and RW SHALL be latched every cycle; strobe end uses values from the last E=1 cycle.
REQ-015 Write strobe = strobe end with latched RW=0; read strobe = latched RW=1.
REQ-016 Two-state write FSM: HI (expect high nibble) and LO (expect low nibble); reset state HI.
REQ-017 HI + write strobe: store nibble as byte_data[7:4] candidate and its RS; go LO.
REQ-018 LO + write strobe, RS equal to stored RS: byte_data <= {hi,lo}, byte_rs <= RS, byte_valid=1 in the cycle after strobe end; go HI.
REQ-019 LO + write strobe, RS differs: no byte, rs_error=1 next cycle, new nibble becomes the stored high nibble; remain LO.
REQ-020 Read strobes SHALL NOT change the write FSM; separate read-phase bit toggles per read strobe, reset 0 (high nibble).
REQ-021 lcd_datain = {busy,3'b000} while E=1, RW=1, read-phase=0; 4'b0000 while E=1, RW=1, read-phase=1; 4'b0000 otherwise (combinational from inputs and registered state).
REQ-022 byte_data/byte_rs hold their value until the next assembled byte.
REQ-023 Back-to-back strobes (E low for one cycle) SHALL each be captured; no minimum E-low gap beyond one cycle.

Reset
REQ-024 On clear: FSM=HI, read-phase=0, e_q=0, byte_data=8'h00, byte_rs=0, byte_valid=0, rs_error=0, busy=0, busy_violation=0, busy counter=0, lcd_datain=4'h0.
REQ-025 clear asserted mid-byte SHALL discard the stored high nibble; first strobe after release is a high nibble.
REQ-026 A falling edge of E coincident with clear deassertion SHALL NOT be captured (e_q is 0 out of reset).

Configuration
REQ-027 Macro LCD_BUSY_MODEL_EN defined: each byte_valid loads a 16-bit counter with BUSY_CYCLES; busy=1 while counter nonzero; counter decrements each clk; write strobe end while busy=1 pulses busy_violation next cycle and is still captured; byte completing while busy reloads counter.
REQ-028 Macro undefined: no counter; busy and busy_violation tied 0; lcd_datain high-nibble read returns 4'h0.

Verification
REQ-029 Writes RS=0 nibbles 4'h3 then 4'h8 -> byte_valid one cycle after second E fall, byte_data=8'h38, byte_rs=0.
REQ-030 Writes RS=1 4'h4, then RS=0 4'h1, then RS=0 4'h5 -> rs_error pulse after second strobe, then byte_data=8'h15, byte_rs=0; no byte 8'h41.
REQ-031 clear pulse after high nibble 4'hA, then writes 4'h4, 4'h2 (RS=1) -> byte_data=8'h42, byte_rs=1; 8'hA4 never produced.
REQ-032 With LCD_BUSY_MODEL_EN, BUSY_CYCLES=40: write 8'h01, read strobe within 10 cycles -> lcd_datain=4'h8 during E; read after 41 cycles -> 4'h0; second write started inside window -> busy_violation pulse.
REQ-033 Without LCD_BUSY_MODEL_EN, same stimulus -> busy=0, busy_violation never asserted, reads return 4'h0.
REQ-034 Interleave read strobe between high nibble 4'h2 and low nibble 4'h8 (RS=1) -> byte_data=8'h28, read-phase toggled to 1.
